ir_fetch_sequencer: RTL and testbench

//  Multi-cycle fetch controller that fills a 16-bit instruction register from byte-wide memory.

---
 rtl/ir_fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ir_fetch_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// ir_fetch_sequencer
//   Multi-cycle fetch controller. It fills a 16-bit instruction register from
//   byte-wide memory with two byte reads. Each accepted byte loads one IR half
//   and increments the PC. The block sits between the CPU control unit
//   (Start/Done) and the PC/IR register instances (FunSel/E controls).
//
// Ports
//   Clock      in   rising-edge system clock
//   Reset      in   synchronous, active-high; all outputs forced low while high
//   Start      in   begin a fetch; accepted only in IDLE, DONE or ERR
//   Stall      in   freezes an in-progress byte request
//   MemReq     out  byte read request to memory
//   MemAck     in   memory byte valid this cycle (only meaningful with MemReq)
//   PC_FunSel  out  PC register function select (000 whenever PC_E = 0)
//   PC_E       out  PC register enable
//   IR_FunSel  out  IR register function select (000 whenever IR_E = 0)
//   IR_E       out  IR register enable
//   Busy       out  high while a byte request is outstanding (REQ_LO, REQ_HI)
//   Done       out  one-cycle pulse after the second byte is loaded
//   Timeout    out  error flag, high while parked in ERR
//   dbg_state  out  current FSM state, for observation only
//
// Memory handshake: MemReq acts as "valid" for the request and MemAck as
// "ready/data valid". A byte transfers in exactly the cycle where both
// MemReq=1 and MemAck=1. MemAck is ignored whenever MemReq=0, which includes
// stalled cycles. All outputs are Mealy: they depend on the state and on the
// inputs of the same cycle.
// ---------------------------------------------------------------------------
module ir_fetch_sequencer #(
  parameter int MEM_WAIT_MAX      = 15,
  parameter int LOW_FIRST         = 1,
  parameter int CLEAR_IR_ON_START = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stall,
  output logic       MemReq,
  input  logic       MemAck,
  output logic [2:0] PC_FunSel,
  output logic       PC_E,
  output logic [2:0] IR_FunSel,
  output logic       IR_E,
  output logic       Busy,
  output logic       Done,
  output logic       Timeout,
  output logic [2:0] dbg_state
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);

  // Function selects of the register instances
  localparam logic [2:0] FS_NONE     = 3'b000;
  localparam logic [2:0] PC_INC      = 3'b001;
  localparam logic [2:0] PC_DEC      = 3'b000;
  localparam logic [2:0] IR_CLEAR    = 3'b011;
  localparam logic [2:0] IR_LOAD_LO  = 3'b101;
  localparam logic [2:0] IR_LOAD_HI  = 3'b110;

  // REQ_LO is the first byte of a fetch and REQ_HI the second. LOW_FIRST
  // decides which IR half each of them loads.
  localparam logic [2:0] FS_FIRST  = (LOW_FIRST != 0) ? IR_LOAD_LO : IR_LOAD_HI;
  localparam logic [2:0] FS_SECOND = (LOW_FIRST != 0) ? IR_LOAD_HI : IR_LOAD_LO;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_LO = 3'd1,
    S_REQ_HI = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    MemReq    = 1'b0;
    PC_FunSel = FS_NONE;
    PC_E      = 1'b0;
    IR_FunSel = FS_NONE;
    IR_E      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Timeout   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        Done    = (state_q == S_DONE);
        Timeout = (state_q == S_ERR);
        if (Start) begin
          state_d = S_REQ_LO;
          cnt_d   = '0;
          if (CLEAR_IR_ON_START != 0) begin
            IR_E      = 1'b1;
            IR_FunSel = IR_CLEAR;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_REQ_LO, S_REQ_HI: begin
        Busy = 1'b1;
        // A stalled cycle is invisible to memory and to the wait counter.
        if (!Stall) begin
          MemReq = 1'b1;
          if (MemAck) begin
            IR_E      = 1'b1;
            IR_FunSel = (state_q == S_REQ_LO) ? FS_FIRST : FS_SECOND;
            PC_E      = 1'b1;
            PC_FunSel = PC_INC;
            cnt_d     = '0;
            state_d   = (state_q == S_REQ_LO) ? S_REQ_HI : S_DONE;
          end else if (cnt_q != WAIT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = S_ERR;
            // Undo the first byte's increment so the PC points at the start
            // of the failed instruction.
            if (state_q == S_REQ_HI) begin
              PC_E      = 1'b1;
              PC_FunSel = PC_DEC;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Reset dominates every output in the cycle it is asserted.
    if (Reset) begin
      MemReq    = 1'b0;
      PC_FunSel = FS_NONE;
      PC_E      = 1'b0;
      IR_FunSel = FS_NONE;
      IR_E      = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      Timeout   = 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ir_fetch_sequencer
//   Two instances share the same stimulus:
//     inst 0: MEM_WAIT_MAX=15, LOW_FIRST=1, CLEAR_IR_ON_START=0
//     inst 1: MEM_WAIT_MAX=3,  LOW_FIRST=0, CLEAR_IR_ON_START=1
//   Each cycle the inputs are driven after the falling edge. The outputs are
//   sampled 1 time unit later and compared with a fetch-level reference model.
//   The model tracks "fetching / bytes received / cycles waited / error".
//   Packed output layout:
//   {MemReq, PC_FunSel[2:0], PC_E, IR_FunSel[2:0], IR_E, Busy, Done, Timeout}
// ---------------------------------------------------------------------------
module tb_ir_fetch_sequencer;

  logic clk = 1'b0;
  logic rst, start, stall, ack;

  logic       memreq   [2];
  logic [2:0] pc_fs    [2];
  logic       pc_e     [2];
  logic [2:0] ir_fs    [2];
  logic       ir_e     [2];
  logic       busy     [2];
  logic       done     [2];
  logic       timeout  [2];
  logic [2:0] dbg      [2];
  logic [11:0] obs     [2];
  logic [11:0] exp_v   [2];

  int vectors = 0;
  int errors  = 0;

  localparam int WMAX [2] = '{15, 3};
  localparam int LF   [2] = '{1, 0};
  localparam int CLR  [2] = '{0, 1};

  always #5 clk = ~clk;

  ir_fetch_sequencer #(.MEM_WAIT_MAX(15), .LOW_FIRST(1), .CLEAR_IR_ON_START(0)) u_dut0 (
    .Clock(clk), .Reset(rst), .Start(start), .Stall(stall), .MemReq(memreq[0]),
    .MemAck(ack), .PC_FunSel(pc_fs[0]), .PC_E(pc_e[0]), .IR_FunSel(ir_fs[0]),
    .IR_E(ir_e[0]), .Busy(busy[0]), .Done(done[0]), .Timeout(timeout[0]),
    .dbg_state(dbg[0])
  );

  ir_fetch_sequencer #(.MEM_WAIT_MAX(3), .LOW_FIRST(0), .CLEAR_IR_ON_START(1)) u_dut1 (
    .Clock(clk), .Reset(rst), .Start(start), .Stall(stall), .MemReq(memreq[1]),
    .MemAck(ack), .PC_FunSel(pc_fs[1]), .PC_E(pc_e[1]), .IR_FunSel(ir_fs[1]),
    .IR_E(ir_e[1]), .Busy(busy[1]), .Done(done[1]), .Timeout(timeout[1]),
    .dbg_state(dbg[1])
  );

  assign obs[0] = {memreq[0], pc_fs[0], pc_e[0], ir_fs[0], ir_e[0], busy[0], done[0], timeout[0]};
  assign obs[1] = {memreq[1], pc_fs[1], pc_e[1], ir_fs[1], ir_e[1], busy[1], done[1], timeout[1]};

  // ---------------- reference model ----------------
  int m_active [2] = '{0, 0};
  int m_bytes  [2] = '{0, 0};
  int m_waited [2] = '{0, 0};
  int m_done   [2] = '{0, 0};
  int m_failed [2] = '{0, 0};
  int n_active [2] = '{0, 0};
  int n_bytes  [2] = '{0, 0};
  int n_waited [2] = '{0, 0};
  int n_done   [2] = '{0, 0};
  int n_failed [2] = '{0, 0};

  task automatic model_eval(input int p);
    logic [2:0] pfs, ifs;
    logic pe, ie, mr, bz, dn, to;
    int   goes_low;
    pfs = 3'b000; ifs = 3'b000;
    pe = 0; ie = 0; mr = 0; bz = 0; dn = 0; to = 0;
    n_active[p] = m_active[p]; n_bytes[p] = m_bytes[p]; n_waited[p] = m_waited[p];
    n_done[p] = m_done[p]; n_failed[p] = m_failed[p];
    if (rst) begin
      n_active[p] = 0; n_bytes[p] = 0; n_waited[p] = 0; n_done[p] = 0; n_failed[p] = 0;
    end else if (m_active[p] == 0) begin
      dn = (m_done[p] != 0);
      to = (m_failed[p] != 0);
      n_done[p] = 0;
      if (start) begin
        n_active[p] = 1; n_bytes[p] = 0; n_waited[p] = 0; n_failed[p] = 0;
        if (CLR[p] != 0) begin ie = 1; ifs = 3'b011; end
      end
    end else begin
      bz = 1;
      if (!stall) begin
        mr = 1;
        if (ack) begin
          goes_low = ((m_bytes[p] == 0) == (LF[p] != 0)) ? 1 : 0;
          ie = 1; ifs = (goes_low != 0) ? 3'b101 : 3'b110;
          pe = 1; pfs = 3'b001;
          n_waited[p] = 0;
          n_bytes[p]  = m_bytes[p] + 1;
          if (n_bytes[p] == 2) begin n_active[p] = 0; n_done[p] = 1; end
        end else if (m_waited[p] < WMAX[p]) begin
          n_waited[p] = m_waited[p] + 1;
        end else begin
          n_active[p] = 0; n_failed[p] = 1;
          if (m_bytes[p] == 1) pe = 1;
        end
      end
    end
    exp_v[p] = {mr, pfs, pe, ifs, ie, bz, dn, to};
  endtask

  // One clock cycle: commit the model's state for the previous edge, drive
  // inputs, let the outputs settle, then compute expected outputs.
  task automatic apply(input logic r, input logic s, input logic st, input logic a);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      m_active[p] = n_active[p]; m_bytes[p] = n_bytes[p]; m_waited[p] = n_waited[p];
      m_done[p] = n_done[p]; m_failed[p] = n_failed[p];
    end
    rst = r; start = s; stall = st; ack = a;
    #1;
    for (int p = 0; p < 2; p++) model_eval(p);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply(1, 0, 0, 0);
    apply(1, 1, 0, 1);
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (obs[p] !== 12'h000) begin
        errors++; $display("FAIL reset_outputs inst%0d got=%h want=%h", p, obs[p], 12'h000);
      end
    end
    apply(0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (obs[p] !== 12'h000) begin
        errors++; $display("FAIL idle_after_reset inst%0d got=%h want=%h", p, obs[p], 12'h000);
      end
    end
  endtask

  task automatic test_fetch();
    logic [11:0] want0 [4];
    logic [11:0] want1 [4];
    want0 = '{12'b0000_0000_0000, 12'b1001_1101_1100, 12'b1001_1110_1100, 12'b0000_0000_0010};
    want1 = '{12'b0000_0011_1000, 12'b1001_1110_1100, 12'b1001_1101_1100, 12'b0000_0000_0010};
    apply(1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) apply(0, 1, 0, 0);
      else if (c < 3) apply(0, 0, 0, 1);
      else apply(0, 0, 0, 0);
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (obs[p] !== exp_v[p]) begin
          errors++; $display("FAIL fetch_model c%0d inst%0d got=%h want=%h", c, p, obs[p], exp_v[p]);
        end
      end
      if (c < 4) begin
        vectors++;
        if (obs[0] !== want0[c] || obs[1] !== want1[c]) begin
          errors++;
          $display("FAIL fetch_fixed c%0d got=%h/%h want=%h/%h", c, obs[0], obs[1], want0[c], want1[c]);
        end
      end else begin
        vectors++;
        if (obs[0] !== 12'h000) begin
          errors++; $display("FAIL fetch_idle got=%h want=%h", obs[0], 12'h000);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int reqs;
    int undo;
    reqs = 0; undo = 0;
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    for (int c = 0; c < 16; c++) begin
      apply(0, 0, 0, 0);
      if (memreq[0] === 1'b1 && busy[0] === 1'b1) reqs++;
      if (pc_e[0] === 1'b1 && pc_fs[0] === 3'b000) undo++;
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (obs[p] !== exp_v[p]) begin
          errors++; $display("FAIL timeout_model c%0d inst%0d got=%h want=%h", c, p, obs[p], exp_v[p]);
        end
      end
    end
    vectors++;
    if (reqs != 16 || undo != 1) begin
      errors++; $display("FAIL timeout_window reqs=%0d undo=%0d want 16/1", reqs, undo);
    end
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 0, 0);
      vectors++;
      if (obs[0] !== 12'h001 || obs[1] !== 12'h001) begin
        errors++; $display("FAIL timeout_sticky got=%h/%h want=001", obs[0], obs[1]);
      end
    end
    apply(0, 1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (obs[p] !== exp_v[p]) begin
        errors++; $display("FAIL timeout_restart inst%0d got=%h want=%h", p, obs[p], exp_v[p]);
      end
    end
    apply(0, 0, 1, 0);
    vectors++;
    if (timeout[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_cleared to=%b busy=%b want 0/1", timeout[0], busy[0]);
    end
  endtask

  task automatic test_stall();
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      apply(0, 0, 1, 1);
      vectors++;
      if (obs[0] !== 12'h004 || obs[1] !== 12'h004) begin
        errors++; $display("FAIL stall_frozen c%0d got=%h/%h want=004", c, obs[0], obs[1]);
      end
    end
    apply(0, 0, 0, 1);
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (obs[p] !== exp_v[p] || ir_e[p] !== 1'b1) begin
        errors++; $display("FAIL stall_release inst%0d got=%h want=%h", p, obs[p], exp_v[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    apply(1, 0, 0, 1);
    vectors++;
    if (obs[0] !== 12'h000 || obs[1] !== 12'h000) begin
      errors++; $display("FAIL reset_mid got=%h/%h want=000", obs[0], obs[1]);
    end
    apply(0, 0, 0, 1);
    vectors++;
    if (obs[0] !== 12'h000 || obs[1] !== 12'h000) begin
      errors++; $display("FAIL reset_mid_idle got=%h/%h want=000", obs[0], obs[1]);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int busys;
    dones = 0; busys = 0;
    apply(1, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      apply(0, 1, 0, 1);
      if (done[0] === 1'b1) dones++;
      if (busy[0] === 1'b1) busys++;
      vectors++;
      if (done[0] !== ((c % 3) == 0 && c > 0)) begin
        errors++; $display("FAIL b2b_done c%0d got=%b want=%b", c, done[0], ((c % 3) == 0 && c > 0));
      end
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (obs[p] !== exp_v[p]) begin
          errors++; $display("FAIL b2b_model c%0d inst%0d got=%h want=%h", c, p, obs[p], exp_v[p]);
        end
      end
    end
    vectors++;
    if (dones != 3 || busys != 6) begin
      errors++; $display("FAIL b2b_counts dones=%0d busy=%0d want 3/6", dones, busys);
    end
  endtask

  task automatic test_random();
    logic r, s, st, a;
    apply(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 2) == 0);
      apply(r, s, st, a);
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (obs[p] !== exp_v[p]) begin
          errors++; $display("FAIL random c%0d inst%0d got=%h want=%h", c, p, obs[p], exp_v[p]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; ack = 1'b0;
    test_reset();
    test_fetch();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
